// File: rtl/rocketcpu_flashcache_pkg.sv
// Shared definitions for the flash read cache: config address, FSM encoding,
// default geometry and the bypass decode.
package rocketcpu_flashcache_pkg;

   localparam logic [31:0] CFG_ADDR       = 32'h0200_0000;
   localparam int          DEF_LINES      = 8;
   localparam int          DEF_LINE_WORDS = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOOKUP = 3'd1,
      ST_FILL   = 3'd2,
      ST_GAP    = 3'd3,
      ST_RESP   = 3'd4,
      ST_BYPASS = 3'd5
   } state_e;

   // Writes and config-register traffic never touch the cache arrays.
   function automatic logic is_bypass(input logic [31:0] adr, input logic we);
      return we || (adr == CFG_ADDR);
   endfunction

endpackage

// File: rtl/rocketcpu_flashcache_if.sv
// Wishbone-style classic bus used on both the CPU side and the flash side.
interface rocketcpu_flashcache_if;
   logic [31:0] adr;
   logic [31:0] dat;
   logic [3:0]  sel;
   logic        we;
   logic        cyc;
   logic [31:0] rdt;
   logic        ack;

   modport master (output adr, dat, sel, we, cyc, input rdt, ack);
   modport slave  (input adr, dat, sel, we, cyc, output rdt, ack);
endinterface

// File: rtl/rocketcpu_flashcache_mem.sv
// Direct-mapped storage: tag+valid per line and a word-addressed data array,
// one shared write port, registered read, and a clear-all for the valid bits.
module rocketcpu_flashcache_mem #(
   parameter int LINES      = 8,
   parameter int LINE_WORDS = 4,
   parameter int TAG_W      = 17
) (
   input  logic                          i_wb_clk,
   input  logic                          reset,
   input  logic [$clog2(LINES)-1:0]      rd_index,
   input  logic [$clog2(LINE_WORDS)-1:0] rd_word,
   input  logic [$clog2(LINES)-1:0]      wr_index,
   input  logic [$clog2(LINE_WORDS)-1:0] wr_word,
   input  logic [31:0]                   wr_data,
   input  logic                          wr_data_en,
   input  logic [TAG_W-1:0]              wr_tag,
   input  logic                          wr_valid,
   input  logic                          wr_tag_en,
   input  logic                          valid_clr,
   output logic [TAG_W-1:0]              rd_tag,
   output logic                          rd_valid,
   output logic [31:0]                   rd_data
);
   logic [TAG_W-1:0] tag_mem_r  [LINES];
   logic [31:0]      data_mem_r [LINES*LINE_WORDS];
   logic [LINES-1:0] valid_r;

   // Valid bits: the only resettable state in the arrays.
   always_ff @(posedge i_wb_clk) begin
      if (reset) begin
         valid_r  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= valid_r[rd_index];
         if (valid_clr) begin
            valid_r <= '0;
         end else if (wr_tag_en) begin
            valid_r[wr_index] <= wr_valid;
         end else begin
            valid_r <= valid_r;
         end
      end
   end

   // Tag/data write port and registered read.
   always_ff @(posedge i_wb_clk) begin
      if (wr_data_en) begin
         data_mem_r[{wr_index, wr_word}] <= wr_data;
      end
      if (wr_tag_en) begin
         tag_mem_r[wr_index] <= wr_tag;
      end
      rd_tag  <= tag_mem_r[rd_index];
      rd_data <= data_mem_r[{rd_index, rd_word}];
   end

endmodule

// File: rtl/rocketcpu_flashcache.sv
// Direct-mapped read cache between the CPU bus and the flash I/O block;
// writes and config accesses pass straight through.
module rocketcpu_flashcache
   import rocketcpu_flashcache_pkg::*;
#(
   parameter int LINES      = DEF_LINES,
   parameter int LINE_WORDS = DEF_LINE_WORDS
) (
   input  logic                   i_wb_clk,
   input  logic                   reset,
   rocketcpu_flashcache_if.slave  wb,
   rocketcpu_flashcache_if.master fl
);
   localparam int WRD_W  = $clog2(LINE_WORDS);
   localparam int IDX_W  = $clog2(LINES);
   localparam int TAG_W  = 22 - WRD_W - IDX_W;
   localparam int TAG_LO = WRD_W + IDX_W + 2;
   localparam logic [WRD_W-1:0] LAST_WORD = WRD_W'(LINE_WORDS - 1);

   state_e            state_r, state_nxt_s;
   logic [31:0]       req_adr_r, req_dat_r;
   logic [3:0]        req_sel_r;
   logic              req_we_r;
   logic [WRD_W-1:0]  cnt_r, cnt_nxt_s;
   logic              ack_r, ack_nxt_s;
   logic [31:0]       rdt_r, rdt_nxt_s;
   logic              fl_cyc_r, fl_we_r;
   logic [31:0]       fl_adr_r, fl_dat_r;
   logic [3:0]        fl_sel_r;
   logic [31:0]       fill_word_r;
   logic              from_fill_r;

   logic              accept_s, fl_ack_s, hit_s;
   logic [31:0]       cur_adr_s, cur_dat_s;
   logic [3:0]        cur_sel_s;
   logic              cur_we_s;
   logic [WRD_W-1:0]  req_word_s, rd_word_s;
   logic [IDX_W-1:0]  req_idx_s, rd_idx_s;
   logic [TAG_W-1:0]  req_tag_s, rd_tag_s;
   logic              rd_valid_s;
   logic [31:0]       rd_data_s;
   logic              wr_data_en_s, wr_tag_en_s, wr_valid_s, valid_clr_s;

   // A request is taken only once the previous ack has dropped, so a master
   // still holding cyc in the ack cycle cannot start a second transfer.
   assign accept_s   = (state_r == ST_IDLE) && wb.cyc && !ack_r;
   assign fl_ack_s   = fl.ack && fl_cyc_r;
   assign cur_adr_s  = (state_r == ST_IDLE) ? wb.adr : req_adr_r;
   assign cur_dat_s  = (state_r == ST_IDLE) ? wb.dat : req_dat_r;
   assign cur_sel_s  = (state_r == ST_IDLE) ? wb.sel : req_sel_r;
   assign cur_we_s   = (state_r == ST_IDLE) ? wb.we  : req_we_r;
   assign req_word_s = req_adr_r[WRD_W+1:2];
   assign req_idx_s  = req_adr_r[TAG_LO-1:WRD_W+2];
   assign req_tag_s  = req_adr_r[23:TAG_LO];
   assign rd_word_s  = cur_adr_s[WRD_W+1:2];
   assign rd_idx_s   = cur_adr_s[TAG_LO-1:WRD_W+2];
   assign hit_s      = rd_valid_s && (rd_tag_s == req_tag_s);

   rocketcpu_flashcache_mem #(
      .LINES(LINES), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W)
   ) u_mem (
      .i_wb_clk(i_wb_clk), .reset(reset),
      .rd_index(rd_idx_s), .rd_word(rd_word_s),
      .wr_index(req_idx_s), .wr_word(cnt_r), .wr_data(fl.rdt), .wr_data_en(wr_data_en_s),
      .wr_tag(req_tag_s), .wr_valid(wr_valid_s), .wr_tag_en(wr_tag_en_s),
      .valid_clr(valid_clr_s),
      .rd_tag(rd_tag_s), .rd_valid(rd_valid_s), .rd_data(rd_data_s)
   );

   // Next-state, array write controls and CPU response.
   always_comb begin
      state_nxt_s  = state_r;
      cnt_nxt_s    = cnt_r;
      ack_nxt_s    = 1'b0;
      rdt_nxt_s    = rdt_r;
      wr_data_en_s = 1'b0;
      wr_tag_en_s  = 1'b0;
      wr_valid_s   = 1'b0;
      valid_clr_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s = is_bypass(wb.adr, wb.we) ? ST_BYPASS : ST_LOOKUP;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOOKUP: begin
            if (hit_s) begin
               state_nxt_s = ST_RESP;
            end else begin
               state_nxt_s = ST_FILL;
               cnt_nxt_s   = '0;
               wr_tag_en_s = 1'b1;
            end
         end
         ST_FILL: begin
            if (fl_ack_s) begin
               wr_data_en_s = 1'b1;
               cnt_nxt_s    = cnt_r + WRD_W'(1);
               if (cnt_r == LAST_WORD) begin
                  state_nxt_s = ST_RESP;
                  wr_tag_en_s = 1'b1;
                  wr_valid_s  = 1'b1;
               end else begin
                  state_nxt_s = ST_GAP;
               end
            end else begin
               state_nxt_s = ST_FILL;
            end
         end
         ST_GAP: begin
            state_nxt_s = ST_FILL;
         end
         ST_RESP: begin
            state_nxt_s = ST_IDLE;
            ack_nxt_s   = wb.cyc;
            rdt_nxt_s   = from_fill_r ? fill_word_r : rd_data_s;
         end
         ST_BYPASS: begin
            if (fl_ack_s) begin
               state_nxt_s = ST_IDLE;
               ack_nxt_s   = wb.cyc;
               rdt_nxt_s   = fl.rdt;
               valid_clr_s = req_we_r && (req_adr_r == CFG_ADDR);
            end else begin
               state_nxt_s = ST_BYPASS;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Control state and registered bus outputs.
   always_ff @(posedge i_wb_clk) begin
      if (reset) begin
         state_r  <= ST_IDLE;
         cnt_r    <= '0;
         ack_r    <= 1'b0;
         rdt_r    <= 32'h0;
         fl_cyc_r <= 1'b0;
         fl_we_r  <= 1'b0;
         fl_adr_r <= 32'h0;
         fl_dat_r <= 32'h0;
         fl_sel_r <= 4'h0;
      end else begin
         state_r  <= state_nxt_s;
         cnt_r    <= cnt_nxt_s;
         ack_r    <= ack_nxt_s;
         rdt_r    <= rdt_nxt_s;
         fl_cyc_r <= (state_nxt_s == ST_FILL) || (state_nxt_s == ST_BYPASS);
         fl_we_r  <= (state_nxt_s == ST_BYPASS) && cur_we_s;
         fl_adr_r <= (state_nxt_s == ST_FILL) ?
                     {8'h00, req_tag_s, req_idx_s, cnt_nxt_s, 2'b00} : cur_adr_s;
         fl_dat_r <= (state_nxt_s == ST_BYPASS) ? cur_dat_s : 32'h0;
         fl_sel_r <= (state_nxt_s == ST_BYPASS) ? cur_sel_s : 4'hF;
      end
   end

   // Request latch and the fill-path copy of the requested word; the array
   // read of the last fill word would otherwise return the pre-write value.
   always_ff @(posedge i_wb_clk) begin
      if (accept_s) begin
         req_adr_r <= wb.adr;
         req_dat_r <= wb.dat;
         req_sel_r <= wb.sel;
         req_we_r  <= wb.we;
      end
      if ((state_r == ST_FILL) && fl_ack_s && (cnt_r == req_word_s)) begin
         fill_word_r <= fl.rdt;
      end
      if (state_r == ST_LOOKUP) begin
         from_fill_r <= !hit_s;
      end
   end

   assign wb.ack = ack_r;
   assign wb.rdt = rdt_r;
   assign fl.cyc = fl_cyc_r;
   assign fl.we  = fl_we_r;
   assign fl.adr = fl_adr_r;
   assign fl.dat = fl_dat_r;
   assign fl.sel = fl_sel_r;

endmodule

// File: tb/tb_rocketcpu_flashcache.sv
// Directed bench for rocketcpu_flashcache: flash responder returns
// adr ^ 32'hDEAD_0000 two cycles after cyc rises, every flash access is logged.
module tb_rocketcpu_flashcache;

   logic i_wb_clk;
   logic reset;

   rocketcpu_flashcache_if wb_if ();
   rocketcpu_flashcache_if fl_if ();

   rocketcpu_flashcache #(.LINES(8), .LINE_WORDS(4)) dut (
      .i_wb_clk(i_wb_clk),
      .reset(reset),
      .wb(wb_if),
      .fl(fl_if)
   );

   int total = 0;
   int bad   = 0;
   int ack_cnt = 0;
   int dbl_ack_err = 0;
   int gap_err = 0;
   bit fl_mute = 1'b0;
   bit spur_req = 1'b0;
   logic [31:0] log_adr [$];
   logic [31:0] log_dat [$];
   logic [3:0]  log_sel [$];
   logic        log_we  [$];

   initial begin
      i_wb_clk = 1'b0;
      forever #5 i_wb_clk = ~i_wb_clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Flash responder: one-cycle ack after cyc has been high for two samples.
   initial begin
      int wait_n;
      wait_n = 0;
      fl_if.ack = 1'b0;
      fl_if.rdt = 32'h0;
      forever begin
         @(negedge i_wb_clk);
         if (fl_if.ack) begin
            fl_if.ack = 1'b0;
            if (fl_if.cyc) gap_err++;
         end else if (spur_req) begin
            fl_if.ack = 1'b1;
            fl_if.rdt = 32'h1234_5678;
            spur_req  = 1'b0;
         end else if (fl_if.cyc && !fl_mute && !reset) begin
            wait_n++;
            if (wait_n >= 2) begin
               fl_if.ack = 1'b1;
               fl_if.rdt = fl_if.adr ^ 32'hDEAD_0000;
               log_adr.push_back(fl_if.adr);
               log_dat.push_back(fl_if.dat);
               log_sel.push_back(fl_if.sel);
               log_we.push_back(fl_if.we);
               wait_n = 0;
            end
         end else begin
            wait_n = 0;
         end
      end
   end

   // CPU-side ack monitor.
   initial begin
      logic prev_ack;
      prev_ack = 1'b0;
      forever begin
         @(negedge i_wb_clk);
         if (wb_if.ack === 1'b1) begin
            ack_cnt++;
            if (prev_ack) dbl_ack_err++;
         end
         prev_ack = (wb_if.ack === 1'b1);
      end
   end

   task automatic wb_xfer(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                          input logic we, output logic [31:0] rdt, output int lat);
      bit got;
      got = 1'b0;
      lat = 0;
      rdt = 32'h0;
      wb_if.adr = adr;
      wb_if.dat = dat;
      wb_if.sel = sel;
      wb_if.we  = we;
      wb_if.cyc = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(posedge i_wb_clk);
         @(negedge i_wb_clk);
         lat++;
         if (wb_if.ack === 1'b1) begin
            rdt = wb_if.rdt;
            got = 1'b1;
            break;
         end
      end
      if (!got) check_val("xfer_timeout", 32'h0, 32'h1);
      wb_if.cyc = 1'b0;
      wb_if.we  = 1'b0;
      @(negedge i_wb_clk);
   endtask

   task automatic wait_log(input int n);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge i_wb_clk);
         if (log_adr.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check_val("log_timeout", 32'(log_adr.size()), 32'(n));
   endtask

   initial begin
      logic [31:0] rdt;
      int lat, base, acks;
      bit seen;
      wb_if.adr = 32'h0;
      wb_if.dat = 32'h0;
      wb_if.sel = 4'h0;
      wb_if.we  = 1'b0;
      wb_if.cyc = 1'b0;
      reset = 1'b1;
      repeat (3) @(posedge i_wb_clk);
      @(negedge i_wb_clk);
      check_val("rst_wb_ack", 32'(wb_if.ack), 32'h0);
      check_val("rst_fl_cyc", 32'(fl_if.cyc), 32'h0);
      check_val("rst_fl_we",  32'(fl_if.we),  32'h0);
      check_val("rst_wb_rdt", wb_if.rdt, 32'h0);
      reset = 1'b0;
      @(negedge i_wb_clk);

      // Cold miss: word 1 requested, whole line filled in order.
      base = log_adr.size();
      acks = ack_cnt;
      wb_xfer(32'h0010_0004, 32'h0, 4'hF, 1'b0, rdt, lat);
      check_val("cold_data", rdt, 32'hDEBD_0004);
      check_val("cold_nfill", 32'(log_adr.size() - base), 32'd4);
      for (int i = 0; i < 4; i++) check_val("cold_fadr", log_adr[base+i], 32'h0010_0000 + 32'(i*4));
      check_val("cold_fwe", 32'(log_we[base]), 32'h0);
      check_val("cold_fsel", 32'(log_sel[base+3]), 32'hF);
      check_val("cold_acks", 32'(ack_cnt - acks), 32'd1);

      // Hit: no flash traffic, ack two edges after the sampling edge.
      base = log_adr.size();
      wb_xfer(32'h0010_0008, 32'h0, 4'hF, 1'b0, rdt, lat);
      check_val("hit_data", rdt, 32'hDEBD_0008);
      check_val("hit_lat", 32'(lat), 32'd3);
      check_val("hit_nfill", 32'(log_adr.size() - base), 32'd0);

      // Same-index conflict evicts and refills.
      base = log_adr.size();
      wb_xfer(32'h0010_0000, 32'h0, 4'hF, 1'b0, rdt, lat);
      check_val("conf_hit0", 32'(log_adr.size() - base), 32'd0);
      wb_xfer(32'h0010_0080, 32'h0, 4'hF, 1'b0, rdt, lat);
      check_val("conf_data80", rdt, 32'hDEBD_0080);
      check_val("conf_nfill80", 32'(log_adr.size() - base), 32'd4);
      wb_xfer(32'h0010_0000, 32'h0, 4'hF, 1'b0, rdt, lat);
      check_val("conf_data0", rdt, 32'hDEBD_0000);
      check_val("conf_nfill0", 32'(log_adr.size() - base), 32'd8);

      // Config write bypasses unchanged and flushes the cache.
      base = log_adr.size();
      wb_xfer(32'h0200_0000, 32'h0000_0080, 4'b0011, 1'b1, rdt, lat);
      check_val("cfg_n", 32'(log_adr.size() - base), 32'd1);
      check_val("cfg_adr", log_adr[base], 32'h0200_0000);
      check_val("cfg_dat", log_dat[base], 32'h0000_0080);
      check_val("cfg_sel", 32'(log_sel[base]), 32'h3);
      check_val("cfg_we",  32'(log_we[base]), 32'h1);
      base = log_adr.size();
      wb_xfer(32'h0010_0004, 32'h0, 4'hF, 1'b0, rdt, lat);
      check_val("flush_nfill", 32'(log_adr.size() - base), 32'd4);
      check_val("flush_data", rdt, 32'hDEBD_0004);

      // Config read is a bypass too.
      base = log_adr.size();
      wb_xfer(32'h0200_0000, 32'h0, 4'hF, 1'b0, rdt, lat);
      check_val("cfgrd_data", rdt, 32'hDCAD_0000);
      check_val("cfgrd_n", 32'(log_adr.size() - base), 32'd1);
      check_val("cfgrd_we", 32'(log_we[base]), 32'h0);

      // Stray flash ack while idle does nothing.
      acks = ack_cnt;
      spur_req = 1'b1;
      repeat (4) @(negedge i_wb_clk);
      check_val("spur_acks", 32'(ack_cnt - acks), 32'd0);
      base = log_adr.size();
      wb_xfer(32'h0010_0008, 32'h0, 4'hF, 1'b0, rdt, lat);
      check_val("spur_hitdata", rdt, 32'hDEBD_0008);
      check_val("spur_nfill", 32'(log_adr.size() - base), 32'd0);

      // CPU abandons the request mid-fill: line still installed, no ack.
      base = log_adr.size();
      acks = ack_cnt;
      wb_if.adr = 32'h0010_0010;
      wb_if.we  = 1'b0;
      wb_if.cyc = 1'b1;
      wait_log(base + 1);
      wb_if.cyc = 1'b0;
      wait_log(base + 4);
      repeat (4) @(negedge i_wb_clk);
      check_val("drop_acks", 32'(ack_cnt - acks), 32'd0);
      base = log_adr.size();
      wb_xfer(32'h0010_0014, 32'h0, 4'hF, 1'b0, rdt, lat);
      check_val("drop_hitdata", rdt, 32'hDEBD_0014);
      check_val("drop_nfill", 32'(log_adr.size() - base), 32'd0);

      // Reset during the third fill word aborts the fill.
      base = log_adr.size();
      acks = ack_cnt;
      wb_if.adr = 32'h0030_0004;
      wb_if.cyc = 1'b1;
      wait_log(base + 2);
      fl_mute = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge i_wb_clk);
         if (fl_if.cyc === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      check_val("rstfill_seen", 32'(seen), 32'h1);
      check_val("rstfill_adr3", fl_if.adr, 32'h0030_0008);
      reset = 1'b1;
      @(posedge i_wb_clk);
      @(negedge i_wb_clk);
      check_val("rstfill_cyc", 32'(fl_if.cyc), 32'h0);
      check_val("rstfill_ack", 32'(wb_if.ack), 32'h0);
      reset = 1'b0;
      wb_if.cyc = 1'b0;
      fl_mute = 1'b0;
      @(negedge i_wb_clk);
      check_val("rstfill_acks", 32'(ack_cnt - acks), 32'd0);
      base = log_adr.size();
      wb_xfer(32'h0030_0004, 32'h0, 4'hF, 1'b0, rdt, lat);
      check_val("refill_n", 32'(log_adr.size() - base), 32'd4);
      check_val("refill_adr0", log_adr[base], 32'h0030_0000);
      check_val("refill_data", rdt, 32'hDE9D_0004);

      check_val("fl_gap_err", 32'(gap_err), 32'd0);
      check_val("dbl_ack_err", 32'(dbl_ack_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rocketcpu_flashcache.md
ROCKETCPU_FLASHCACHE -- requirements
Module: rocketcpu_flashcache

Interface
REQ-001 Parameter: LINES, 8, number of direct-mapped lines (power of two, 2..32).
REQ-002 Parameter: LINE_WORDS, 4, 32-bit words per line (power of two, 2..8).
REQ-003 i_wb_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 i_wb_adr  input  32  CPU-side byte address.
REQ-006 i_wb_dat  input  32  CPU-side write data.
REQ-007 i_wb_sel  input  4  CPU-side byte enables.
REQ-008 i_wb_we  input  1  CPU-side write strobe.
REQ-009 i_wb_cyc  input  1  CPU-side request; held until ack.
REQ-010 o_wb_rdt  output  32  CPU-side read data, valid with o_wb_ack.
REQ-011 o_wb_ack  output  1  CPU-side one-cycle acknowledge.
REQ-012 o_fl_adr, o_fl_dat, o_fl_sel, o_fl_we, o_fl_cyc  output  32/32/4/1/1  master port to flash I/O block.
REQ-013 i_fl_rdt, i_fl_ack  input  32/1  flash I/O block read data and one-cycle ack.

Function
REQ-014 Address split: word = adr[log2(LINE_WORDS)+1:2], index = next log2(LINES) bits, tag = remaining bits up to adr[23]; adr[31:24] ignored except for config decode.
REQ-015 Config address CFG_ADDR = 32'h0200_0000; any access to it, and every write, SHALL be a bypass: forwarded unchanged on the master port, never cached.
REQ-016 A write to CFG_ADDR SHALL clear all valid bits in the cycle its i_fl_ack arrives.
REQ-017 States: IDLE, LOOKUP, FILL, GAP, RESP, BYPASS.
REQ-018 IDLE -> LOOKUP when i_wb_cyc high and not bypass; IDLE -> BYPASS when bypass.
REQ-019 LOOKUP: hit (valid and tag match) -> RESP; miss -> FILL with fill counter 0, line valid bit cleared.
REQ-020 Hit latency: o_wb_ack high exactly 2 cycles after i_wb_cyc first sampled high in IDLE.
REQ-021 FILL: o_fl_cyc high, o_fl_we low, o_fl_sel 4'hF, o_fl_adr = {tag, index, counter, 2'b00}; held stable until i_fl_ack.
REQ-022 On each fill i_fl_ack: store i_fl_rdt at counter, go GAP (o_fl_cyc low one cycle), increment counter; after word LINE_WORDS-1 set valid, write tag, go RESP.
REQ-023 Fill order SHALL be word 0 to LINE_WORDS-1 regardless of requested word.
REQ-024 RESP: o_wb_ack high one cycle, o_wb_rdt = line[word]; next state IDLE.
REQ-025 BYPASS: o_fl_* mirror latched CPU request; on i_fl_ack, o_wb_rdt <= i_fl_rdt and o_wb_ack pulses next cycle, then IDLE.
REQ-026 o_wb_ack SHALL never be high on consecutive cycles; o_fl_cyc SHALL be low at least one cycle between master transactions.
REQ-027 CPU drops i_wb_cyc mid-fill: fill completes, line installed, no o_wb_ack.
REQ-028 i_fl_ack while o_fl_cyc low SHALL be ignored.

Reset
REQ-029 On reset: state IDLE, all valid bits 0, o_wb_ack 0, o_fl_cyc 0, o_fl_we 0, o_wb_rdt 0, fill counter 0, next cycle.
REQ-030 Reset mid-fill or mid-bypass SHALL abort: o_fl_cyc low the cycle after reset is sampled; partial line stays invalid.
REQ-031 Data and tag arrays need no reset.

Structure
REQ-032 Shared package holds CFG_ADDR, the state encoding, and default LINES/LINE_WORDS.
REQ-033 One sub-module rocketcpu_flashcache_mem: tag+valid and data arrays, one write port, registered read; valid clear-all input.

Verification
REQ-034 Read 0x0010_0004 cold -> 4 master reads 0x0010_0000..0x0010_000C, each separated by cyc-low cycle; CPU gets word 1 data, one ack.
REQ-035 Repeat read 0x0010_0008 -> no o_fl_cyc, ack 2 cycles after cyc, data = word 2.
REQ-036 Read 0x0010_0000 then 0x0010_0080 (same index, LINES=8, LINE_WORDS=4) -> second misses and refills; re-read of 0x0010_0000 misses again.
REQ-037 Write 0x0000_0080 to CFG_ADDR -> forwarded with we=1, sel passed; then re-read of cached 0x0010_0004 refills.
REQ-038 Assert reset during third fill word -> o_fl_cyc low next cycle, no ack; following read of same address performs full 4-word fill.
